sram_voice_scheduler: RTL and testbench

Read-side scheduler that shares the single board SRAM (read-only, samples preloaded) between `NUM_VOICES` sampler voices. On each audio sample tick it walks the active voices in fixed order, fetches one 16-bit signed sample per voice, and sums them with saturation. The mixed word goes to the DAC data mux in place of the single-voice note path. It owns `SRAM_ADDR` and `SRAM_OE_N`; write enable stays tied inactive at top level.

---
 rtl/sram_voice_scheduler.sv | 157 +++++++++++++++
 tb/tb_sram_voice_scheduler.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_voice_scheduler.sv
// Multi-voice sampler read scheduler: on each sample tick it fetches one word per active voice
// from the shared SRAM and outputs their saturated sum. Define SAMPLER_LOOP_EN for looping voices.
module sram_voice_scheduler #(
   parameter int NUM_VOICES = 4,
   parameter int ADDR_W     = 20,
   parameter int READ_WAIT  = 2
) (
   input  logic                         Clk,
   input  logic                         Reset_n,
   input  logic                         sample_tick,
   input  logic [NUM_VOICES-1:0]        trig,
   input  logic [NUM_VOICES*ADDR_W-1:0] start_addr,
   input  logic [NUM_VOICES*ADDR_W-1:0] end_addr,
   input  logic [15:0]                  sram_data,
   output logic [ADDR_W-1:0]            sram_addr,
   output logic                         sram_oe_n,
   output logic [15:0]                  mix_out,
   output logic                         mix_valid,
   output logic                         busy,
   output logic [NUM_VOICES-1:0]        voice_active,
   output logic                         overrun
);

   localparam int ACC_W  = 16 + $clog2(NUM_VOICES);
   localparam int VIDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
   localparam int WAIT_W = (READ_WAIT > 1) ? $clog2(READ_WAIT) : 1;
   localparam logic [WAIT_W-1:0]       WAIT_LAST = WAIT_W'(READ_WAIT - 1);
   localparam logic signed [ACC_W-1:0] SAT_MAX   = ACC_W'(32767);
   localparam logic signed [ACC_W-1:0] SAT_MIN   = ACC_W'(-32768);

   typedef enum logic [2:0] {S_IDLE, S_SCAN, S_FETCH, S_ACCUM, S_DONE} state_t;

   state_t                   state_q, state_d;
   logic [NUM_VOICES-1:0]    active_q, pend_q, served_q;
   logic [ADDR_W-1:0]        ptr_q   [NUM_VOICES];
   logic [ADDR_W-1:0]        start_v [NUM_VOICES];
   logic [ADDR_W-1:0]        end_v   [NUM_VOICES];
   logic [VIDX_W-1:0]        cur_v, next_v;
   logic                     found;
   logic [WAIT_W-1:0]        wait_q;
   logic signed [ACC_W-1:0]  acc_q;
   logic                     tick_accept;

   function automatic logic [15:0] saturate(input logic signed [ACC_W-1:0] a);
      if (a > SAT_MAX)      return 16'h7FFF;
      else if (a < SAT_MIN) return 16'h8000;
      else                  return a[15:0];
   endfunction

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      found  = 1'b0;
      next_v = '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
         start_v[i] = start_addr[i*ADDR_W +: ADDR_W];
         end_v[i]   = end_addr[i*ADDR_W +: ADDR_W];
      end
      // Descending walk so the lowest-index unserved voice wins.
      for (int i = NUM_VOICES - 1; i >= 0; i--) begin
         if (active_q[i] && !served_q[i]) begin
            found  = 1'b1;
            next_v = VIDX_W'(i);
         end
      end
   end

   assign tick_accept  = (state_q == S_IDLE) && sample_tick;
   assign voice_active = active_q;

   // NOTE: sequential state uses non-blocking assignments so all processes see pre-edge values.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (sample_tick) state_d = S_SCAN;
         S_SCAN:  state_d = found ? S_FETCH : S_DONE;
         S_FETCH: if (wait_q == WAIT_LAST) state_d = S_ACCUM;
         S_ACCUM: state_d = S_SCAN;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      sram_oe_n = (state_q != S_FETCH);
      busy      = (state_q != S_IDLE);
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         // NOTE: the pointer file is only NUM_VOICES registers and must read 0 after reset, so it is reset here.
         for (int i = 0; i < NUM_VOICES; i++) ptr_q[i] <= '0;
         active_q  <= '0;
         pend_q    <= '0;
         served_q  <= '0;
         cur_v     <= '0;
         wait_q    <= '0;
         acc_q     <= '0;
         sram_addr <= '0;
         mix_out   <= '0;
         mix_valid <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         mix_valid <= 1'b0;
         if (sample_tick && (state_q != S_IDLE)) overrun <= 1'b1;

         if (tick_accept) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
               if (pend_q[i] || trig[i]) begin
                  active_q[i] <= 1'b1;
                  ptr_q[i]    <= start_v[i];
               end
            end
            pend_q   <= '0;
            served_q <= '0;
            acc_q    <= '0;
         end else begin
            pend_q <= pend_q | trig;
         end

         case (state_q)
            S_SCAN: begin
               if (found) begin
                  cur_v            <= next_v;
                  sram_addr        <= ptr_q[next_v];
                  wait_q           <= '0;
                  served_q[next_v] <= 1'b1;
               end else begin
                  mix_out   <= saturate(acc_q);
                  mix_valid <= 1'b1;
               end
            end
            S_FETCH: wait_q <= wait_q + 1'b1;
            S_ACCUM: begin
               acc_q <= acc_q + ACC_W'($signed(sram_data));
               // ">=" also stops a voice whose start lies beyond its end after one sample.
               if (ptr_q[cur_v] >= end_v[cur_v]) begin
`ifdef SAMPLER_LOOP_EN
                  ptr_q[cur_v] <= start_v[cur_v];
`else
                  active_q[cur_v] <= 1'b0;
`endif
               end else begin
                  ptr_q[cur_v] <= ptr_q[cur_v] + ADDR_W'(1);
               end
            end
            S_DONE:  acc_q <= '0;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sram_voice_scheduler.sv
// Directed bench for sram_voice_scheduler: per-scenario tasks with hand-computed expectations.
// Expectations follow SAMPLER_LOOP_EN when it is defined.
module tb_sram_voice_scheduler;

   localparam int NV = 4;
   localparam int AW = 20;
   localparam int RW = 2;

   logic           Clk         = 1'b0;
   logic           Reset_n     = 1'b0;
   logic           sample_tick = 1'b0;
   logic [NV-1:0]  trig        = '0;
   logic [NV*AW-1:0] start_addr = '0;
   logic [NV*AW-1:0] end_addr   = '0;
   logic [15:0]    sram_data   = '0;
   logic [AW-1:0]  sram_addr;
   logic           sram_oe_n;
   logic [15:0]    mix_out;
   logic           mix_valid;
   logic           busy;
   logic [NV-1:0]  voice_active;
   logic           overrun;

   int total = 0;
   int bad   = 0;

   logic        use_fixed  = 1'b0;
   logic [15:0] fixed_word = '0;

   sram_voice_scheduler #(.NUM_VOICES(NV), .ADDR_W(AW), .READ_WAIT(RW)) dut (
      .Clk(Clk), .Reset_n(Reset_n), .sample_tick(sample_tick), .trig(trig),
      .start_addr(start_addr), .end_addr(end_addr), .sram_data(sram_data),
      .sram_addr(sram_addr), .sram_oe_n(sram_oe_n), .mix_out(mix_out),
      .mix_valid(mix_valid), .busy(busy), .voice_active(voice_active), .overrun(overrun)
   );

   always #10 Clk = ~Clk;

   // Registered SRAM read path: either the low address bits or a fixed word.
   always @(posedge Clk) sram_data <= use_fixed ? fixed_word : sram_addr[15:0];

   int            mv_count = 0;
   int            fetch_n  = 0;
   logic [AW-1:0] fetch_log [256];
   logic          oe_prev  = 1'b1;
   always @(posedge Clk) begin
      if (mix_valid) mv_count <= mv_count + 1;
      if (!sram_oe_n && oe_prev && fetch_n < 256) begin
         fetch_log[fetch_n] <= sram_addr;
         fetch_n <= fetch_n + 1;
      end
      oe_prev <= sram_oe_n;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish (time=%0t limit=2000000)", $time);
      $fatal(1, "watchdog");
   end

   task automatic cycle();
      @(posedge Clk);
      #1;
   endtask

   task automatic do_reset();
      sample_tick = 1'b0;
      trig        = '0;
      #3 Reset_n  = 1'b0;
      cycle();
      cycle();
      Reset_n = 1'b1;
      cycle();
   endtask

   // Tick high during cycle 0; latency counts cycles until mix_valid is observed.
   task automatic run_tick(input int trig_at, input logic [NV-1:0] mask,
                           output int lat, output logic [15:0] mo, output logic busy1);
      int n;
      sample_tick = 1'b1;
      trig = (trig_at == 0) ? mask : '0;
      cycle();
      sample_tick = 1'b0;
      n     = 1;
      busy1 = busy;
      trig  = (trig_at == 1) ? mask : '0;
      while (!mix_valid && n < 200) begin
         cycle();
         n++;
         trig = (trig_at == n) ? mask : '0;
      end
      lat  = mix_valid ? n : -1;
      mo   = mix_out;
      trig = '0;
      cycle();
   endtask

   task automatic test_reset();
      Reset_n = 1'b0;
      cycle();
      cycle();
      total++; if (sram_addr !== '0) begin bad++; $display("FAIL reset sram_addr: got %h expected 0", sram_addr); end
      total++; if (sram_oe_n !== 1'b1) begin bad++; $display("FAIL reset sram_oe_n: got %b expected 1", sram_oe_n); end
      total++; if (mix_out !== 16'h0) begin bad++; $display("FAIL reset mix_out: got %h expected 0000", mix_out); end
      total++; if (mix_valid !== 1'b0) begin bad++; $display("FAIL reset mix_valid: got %b expected 0", mix_valid); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset busy: got %b expected 0", busy); end
      total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset overrun: got %b expected 0", overrun); end
      total++; if (voice_active !== '0) begin bad++; $display("FAIL reset voice_active: got %b expected 0000", voice_active); end
      Reset_n = 1'b1;
      cycle();
   endtask

   task automatic test_empty_tick();
      int lat; logic [15:0] mo; logic b1; int f0;
      f0 = fetch_n;
      run_tick(-1, '0, lat, mo, b1);
      total++; if (lat !== 2) begin bad++; $display("FAIL empty latency: got %0d expected 2", lat); end
      total++; if (mo !== 16'h0000) begin bad++; $display("FAIL empty mix_out: got %h expected 0000", mo); end
      total++; if (b1 !== 1'b1) begin bad++; $display("FAIL empty busy cycle1: got %b expected 1", b1); end
      total++; if (fetch_n !== f0) begin bad++; $display("FAIL empty oe_n low count: got %0d expected 0", fetch_n - f0); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL empty busy after frame: got %b expected 0", busy); end
   endtask

   task automatic test_one_shot();
      int lat; logic [15:0] mo; logic b1;
      logic [15:0] exp_mix [4];
      int          exp_lat [4];
      logic        exp_act [4];
`ifdef SAMPLER_LOOP_EN
      exp_mix = '{16'h0010, 16'h0011, 16'h0012, 16'h0010};
      exp_lat = '{6, 6, 6, 6};
      exp_act = '{1'b1, 1'b1, 1'b1, 1'b1};
`else
      exp_mix = '{16'h0010, 16'h0011, 16'h0012, 16'h0000};
      exp_lat = '{6, 6, 6, 2};
      exp_act = '{1'b1, 1'b1, 1'b0, 1'b0};
`endif
      start_addr[0*AW +: AW] = 20'h00010;
      end_addr[0*AW +: AW]   = 20'h00012;
      use_fixed = 1'b0;
      trig = 4'b0001;
      cycle();
      trig = '0;
      cycle();
      total++; if (voice_active !== 4'b0000) begin bad++; $display("FAIL one_shot pending before tick: got %b expected 0000", voice_active); end
      for (int k = 0; k < 4; k++) begin
         run_tick(-1, '0, lat, mo, b1);
         total++; if (mo !== exp_mix[k]) begin bad++; $display("FAIL one_shot mix tick%0d: got %h expected %h", k, mo, exp_mix[k]); end
         total++; if (lat !== exp_lat[k]) begin bad++; $display("FAIL one_shot latency tick%0d: got %0d expected %0d", k, lat, exp_lat[k]); end
         total++; if (voice_active[0] !== exp_act[k]) begin bad++; $display("FAIL one_shot active tick%0d: got %b expected %b", k, voice_active[0], exp_act[k]); end
         if (k == 0) begin
            total++; if (fetch_log[fetch_n-1] !== 20'h00010) begin bad++; $display("FAIL one_shot first addr: got %h expected 00010", fetch_log[fetch_n-1]); end
         end
      end
   endtask

   task automatic test_saturation();
      int lat; logic [15:0] mo; logic b1; int f0;
      logic [15:0] words [4];
      logic [15:0] exp_mix [4];
      words   = '{16'h7000, 16'h9000, 16'h1234, 16'hF000};
      exp_mix = '{16'h7FFF, 16'h8000, 16'h2468, 16'hE000};
      do_reset();
      start_addr[0*AW +: AW] = 20'h00100; end_addr[0*AW +: AW] = 20'h001FF;
      start_addr[1*AW +: AW] = 20'h00200; end_addr[1*AW +: AW] = 20'h002FF;
      start_addr[2*AW +: AW] = 20'h00300; end_addr[2*AW +: AW] = 20'h003FF;
      use_fixed = 1'b1;
      for (int k = 0; k < 4; k++) begin
         fixed_word = words[k];
         f0 = fetch_n;
         // First tick carries the trigger in the same cycle, so it applies immediately.
         run_tick((k == 0) ? 0 : -1, 4'b0101, lat, mo, b1);
         total++; if (mo !== exp_mix[k]) begin bad++; $display("FAIL sat mix word=%h: got %h expected %h", words[k], mo, exp_mix[k]); end
         total++; if (lat !== 10) begin bad++; $display("FAIL sat latency k=%0d: got %0d expected 10", k, lat); end
         total++; if (fetch_n - f0 !== 2) begin bad++; $display("FAIL sat fetch count k=%0d: got %0d expected 2", k, fetch_n - f0); end
         total++; if (fetch_log[f0] !== 20'h00100 + AW'(k)) begin bad++; $display("FAIL sat addr v0 k=%0d: got %h expected %h", k, fetch_log[f0], 20'h00100 + AW'(k)); end
         total++; if (fetch_log[f0+1] !== 20'h00300 + AW'(k)) begin bad++; $display("FAIL sat addr v2 k=%0d: got %h expected %h", k, fetch_log[f0+1], 20'h00300 + AW'(k)); end
      end
   endtask

   task automatic test_overrun();
      int lat; logic [15:0] mo; logic b1; int m0;
      total++; if (overrun !== 1'b0) begin bad++; $display("FAIL overrun initial: got %b expected 0", overrun); end
      m0 = mv_count;
      sample_tick = 1'b1;
      cycle();
      sample_tick = 1'b0;
      cycle();
      cycle();
      sample_tick = 1'b1;
      cycle();
      sample_tick = 1'b0;
      total++; if (overrun !== 1'b1) begin bad++; $display("FAIL overrun set: got %b expected 1", overrun); end
      repeat (20) cycle();
      total++; if (mv_count - m0 !== 1) begin bad++; $display("FAIL overrun mix_valid count: got %0d expected 1", mv_count - m0); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL overrun busy after: got %b expected 0", busy); end
      run_tick(-1, '0, lat, mo, b1);
      total++; if (lat !== 10) begin bad++; $display("FAIL overrun next latency: got %0d expected 10", lat); end
      total++; if (overrun !== 1'b1) begin bad++; $display("FAIL overrun sticky: got %b expected 1", overrun); end
   endtask

   task automatic test_retrigger();
      int lat; logic [15:0] mo; logic b1;
      do_reset();
      use_fixed = 1'b0;
      start_addr[1*AW +: AW] = 20'h00500;
      end_addr[1*AW +: AW]   = 20'h005FF;
      for (int k = 0; k < 5; k++) run_tick((k == 0) ? 0 : -1, 4'b0010, lat, mo, b1);
      total++; if (mo !== 16'h0504) begin bad++; $display("FAIL retrig fifth mix: got %h expected 0504", mo); end
      run_tick(3, 4'b0010, lat, mo, b1);
      total++; if (mo !== 16'h0505) begin bad++; $display("FAIL retrig frame in flight: got %h expected 0505", mo); end
      total++; if (lat !== 6) begin bad++; $display("FAIL retrig latency: got %0d expected 6", lat); end
      run_tick(-1, '0, lat, mo, b1);
      total++; if (mo !== 16'h0500) begin bad++; $display("FAIL retrig restart mix: got %h expected 0500", mo); end
      total++; if (fetch_log[fetch_n-1] !== 20'h00500) begin bad++; $display("FAIL retrig restart addr: got %h expected 00500", fetch_log[fetch_n-1]); end
      run_tick(-1, '0, lat, mo, b1);
      total++; if (mo !== 16'h0501) begin bad++; $display("FAIL retrig continue mix: got %h expected 0501", mo); end
   endtask

   task automatic test_reversed_range();
      int lat; logic [15:0] mo; logic b1;
      logic [15:0] exp_mix2; int exp_lat2; logic exp_act;
`ifdef SAMPLER_LOOP_EN
      exp_mix2 = 16'h0040; exp_lat2 = 6; exp_act = 1'b1;
`else
      exp_mix2 = 16'h0000; exp_lat2 = 2; exp_act = 1'b0;
`endif
      do_reset();
      use_fixed = 1'b0;
      start_addr[3*AW +: AW] = 20'h00040;
      end_addr[3*AW +: AW]   = 20'h00020;
      run_tick(0, 4'b1000, lat, mo, b1);
      total++; if (mo !== 16'h0040) begin bad++; $display("FAIL reversed first mix: got %h expected 0040", mo); end
      total++; if (voice_active[3] !== exp_act) begin bad++; $display("FAIL reversed active: got %b expected %b", voice_active[3], exp_act); end
      run_tick(-1, '0, lat, mo, b1);
      total++; if (mo !== exp_mix2) begin bad++; $display("FAIL reversed second mix: got %h expected %h", mo, exp_mix2); end
      total++; if (lat !== exp_lat2) begin bad++; $display("FAIL reversed second latency: got %0d expected %0d", lat, exp_lat2); end
   endtask

   task automatic test_reset_abort();
      int m0;
      do_reset();
      use_fixed = 1'b0;
      start_addr[0*AW +: AW] = 20'h00010;
      end_addr[0*AW +: AW]   = 20'h00012;
      sample_tick = 1'b1;
      trig = 4'b0001;
      cycle();
      sample_tick = 1'b0;
      trig = '0;
      cycle();
      total++; if (sram_oe_n !== 1'b0) begin bad++; $display("FAIL abort in fetch oe_n: got %b expected 0", sram_oe_n); end
      total++; if (voice_active[0] !== 1'b1) begin bad++; $display("FAIL abort in fetch active: got %b expected 1", voice_active[0]); end
      m0 = mv_count;
      #3 Reset_n = 1'b0;
      #1;
      total++; if (sram_oe_n !== 1'b1) begin bad++; $display("FAIL abort oe_n: got %b expected 1", sram_oe_n); end
      total++; if (voice_active !== 4'b0000) begin bad++; $display("FAIL abort voice_active: got %b expected 0000", voice_active); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort busy: got %b expected 0", busy); end
      total++; if (sram_addr !== '0) begin bad++; $display("FAIL abort sram_addr: got %h expected 0", sram_addr); end
      cycle();
      cycle();
      Reset_n = 1'b1;
      repeat (10) cycle();
      total++; if (mv_count !== m0) begin bad++; $display("FAIL abort partial mix_valid: got %0d pulses expected 0", mv_count - m0); end
      total++; if (mix_out !== 16'h0000) begin bad++; $display("FAIL abort mix_out: got %h expected 0000", mix_out); end
   endtask

   initial begin
      test_reset();
      test_empty_tick();
      test_one_shot();
      test_saturation();
      test_overrun();
      test_retrigger();
      test_reversed_range();
      test_reset_abort();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
